cube_root: RTL
==============

CUBE_ROOT -- requirements
Module: cube_root

Interface
REQ-001 SHALL have one clock and reset: asynchronous, active-high; all state elements clear immediately on rst_i=1, independent of clk_i.
REQ-002 SHALL expose ports: clk_i  input  1  rising-edge clock.
REQ-003 SHALL expose: rst_i  input  1  asynchronous active-high reset.
REQ-004 SHALL expose: x_bi  input  24  unsigned radicand, sampled only on accepted start.
REQ-005 SHALL expose: start_i  input  1  request pulse/level, sampled each clock edge.
REQ-006 SHALL expose: busy_o  output  1  high while a computation is in progress.
REQ-007 SHALL expose: y_bo  output  8  registered result floor(cbrt(x)), held until next completion or reset.

Function
REQ-008 SHALL compute y = floor(cube root of x_bi) exactly for every 24-bit value; maximum result is 255.
REQ-009 SHALL implement states IDLE, PREP, TEST; busy_o = 1 in PREP or TEST, 0 in IDLE.
REQ-010 IDLE: on edge with start_i=1, SHALL latch x_bi into a 24-bit remainder register, clear partial root (8 bits), set iteration index i=7, go to PREP; start_i=0 stays in IDLE.
REQ-011 PREP: SHALL double partial root (y<<1) and register bound b = (3*y2*(y2+1) + 1) << (3*i), y2 = doubled root, using internal width >= 32 bits so no truncation occurs; go to TEST.
REQ-012 TEST: if remainder >= b, SHALL subtract b from remainder and increment root; otherwise both unchanged.
REQ-013 TEST with i>0: SHALL decrement i and go to PREP; with i=0: SHALL write final root (including this step's increment) to y_bo and go to IDLE in the same edge.
REQ-014 Latency SHALL be fixed at 16 cycles: y_bo updates and busy_o falls on the 16th rising edge after the edge that accepted start_i; no data-dependent early exit, including x_bi=0.
REQ-015 start_i while busy_o=1 SHALL be ignored; no restart, no effect on result.
REQ-016 Changes on x_bi after acceptance SHALL not affect the running computation.
REQ-017 start_i=1 on the cycle busy_o returns to 0 SHALL be accepted on the next edge (back-to-back operation, one IDLE cycle minimum).
REQ-018 y_bo SHALL change only on completion or reset; it holds the previous result throughout a new computation.
REQ-019 Design SHALL be self-contained: no multiplier submodule instance; constant-factor multiply by 3 and y2*(y2+1) may be combinational within PREP.

Reset
REQ-020 On rst_i=1: state=IDLE, busy_o=0, y_bo=0, remainder, root, bound and index cleared.
REQ-021 Reset asserted mid-computation SHALL abort it immediately with no later result write; after release block accepts a new start normally.
REQ-022 start_i=1 coincident with rst_i=1 SHALL be ignored.

Verification
REQ-023 x=27, start 1 cycle -> busy_o high 16 cycles, then y_bo=3, busy_o=0.
REQ-024 x=0, 1, 7, 8, 26, 1000000, 16777215 -> y_bo=0, 1, 1, 2, 2, 100, 255 respectively, each after exactly 16 cycles.
REQ-025 x=64 accepted, x_bi changed to 1000 and start_i pulsed at cycle 5 -> y_bo=4 at cycle 16, no restart.
REQ-026 x=125000 accepted, rst_i pulsed at cycle 8 -> busy_o=0, y_bo=0 immediately; new start x=343 -> y_bo=7 after 16 cycles.
REQ-027 Back-to-back: x=512 then start held high on completion cycle with x=729 -> y_bo=8, then y_bo=9 16 cycles after second acceptance.
REQ-028 Exhaustive/random sweep of x over 24 bits against reference model floor(cbrt(x)) -> zero mismatches.

Source files
------------

// File: rtl/cube_root.sv
// cube_root: iterative integer cube root, y = floor(cbrt(x)) for 24-bit x.
// Restoring digit-by-digit method, one result bit per PREP/TEST pair, so
// every computation takes exactly 16 clocks after the accepting edge.
module cube_root (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [23:0] x_bi,
    input  logic        start_i,
    output logic        busy_o,
    output logic [7:0]  y_bo
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PREP = 2'd1;
    localparam logic [1:0] ST_TEST = 2'd2;

    logic [1:0]  state_q;
    logic [23:0] rem_q;
    logic [7:0]  root_q;
    logic [31:0] bound_q;
    logic [2:0]  idx_q;

    logic [7:0]  y2;
    logic [31:0] y2_w;
    logic [31:0] prod;
    logic [31:0] tri_term;
    logic [4:0]  shamt;
    logic [31:0] bound_d;
    logic        fits;
    logic [7:0]  root_inc;

    // Bound for the next result bit: (3*y2*(y2+1) + 1) << 3i, y2 = 2*root.
    // The root is at most 7 bits wide before doubling, so the shift is lossless.
    always_comb begin
        y2       = {root_q[6:0], 1'b0};
        y2_w     = {24'd0, y2};
        prod     = y2_w * (y2_w + 32'd1);
        tri_term = (prod << 1) + prod + 32'd1;
        shamt    = {1'b0, idx_q, 1'b0} + {2'b0, idx_q};
        bound_d  = tri_term << shamt;
        fits     = ({8'd0, rem_q} >= bound_q);
        root_inc = root_q + {7'd0, fits};
    end

    assign busy_o = (state_q != ST_IDLE);

    // Sequencer and datapath: accept in IDLE, alternate PREP/TEST for 8 bits.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            rem_q   <= 24'd0;
            root_q  <= 8'd0;
            bound_q <= 32'd0;
            idx_q   <= 3'd0;
            y_bo    <= 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        rem_q   <= x_bi;
                        root_q  <= 8'd0;
                        idx_q   <= 3'd7;
                        state_q <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    root_q  <= y2;
                    bound_q <= bound_d;
                    state_q <= ST_TEST;
                end
                ST_TEST: begin
                    if (fits) begin
                        // fits implies bound_q < 2^24, so the low bits suffice
                        rem_q  <= rem_q - bound_q[23:0];
                        root_q <= root_inc;
                    end
                    if (idx_q == 3'd0) begin
                        y_bo    <= root_inc;
                        state_q <= ST_IDLE;
                    end else begin
                        idx_q   <= idx_q - 3'd1;
                        state_q <= ST_PREP;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
